// File: rtl/pipe_delay_reg.sv
// -----------------------------------------------------------------------------
// pipe_delay_reg
//   WIDTH-bit, DEPTH-stage delay line with per-stage valid bits, stall enable,
//   synchronous flush and a registered occupancy count.
//
//   Optional build macro: PIPE_DELAY_REG_TAPS_EN
//     When defined, every stage's data and valid bit are exported on taps_o /
//     tap_vld_o as direct register views. When undefined those ports do not
//     exist and the core behaves identically.
// -----------------------------------------------------------------------------
module pipe_delay_reg #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o,
  output logic [CNT_W-1:0] fill_o,
  output logic             full_o
`ifdef PIPE_DELAY_REG_TAPS_EN
  ,
  output logic [DEPTH*WIDTH-1:0] taps_o,
  output logic [DEPTH-1:0]       tap_vld_o
`endif
);

  // Stage storage: index 0 is the input stage, DEPTH-1 drives the outputs.
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_fill;

  // Next occupancy value for an enabled, non-flushing edge.
  logic [CNT_W-1:0] w_fill_nxt;

  // Number of valid stages recomputed from the valid bits (invariant check).
  logic [CNT_W-1:0] w_popcount;

  // Shift register: reset > flush > advance > hold.
  // NOTE: the data array is reset too, not just the valid bits, so q_o and
  // the taps are never X even for stages that were never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_vld <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_vld <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value, so the loop order does not matter.
      r_data[0] <= d_i;
      r_vld[0]  <= vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
    end
  end

  // Occupancy delta: one word in, one word out, both, or neither.
  always_comb begin
    // NOTE: default first so every path assigns w_fill_nxt and no latch forms.
    w_fill_nxt = r_fill;
    if (vld_i && !r_vld[DEPTH-1]) begin
      w_fill_nxt = r_fill + CNT_W'(1);
    end else if (!vld_i && r_vld[DEPTH-1]) begin
      w_fill_nxt = r_fill - CNT_W'(1);
    end
  end

  // Occupancy register, moves only on edges that actually shift the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill <= '0;
    end else if (clr_i) begin
      r_fill <= '0;
    end else if (en_i) begin
      r_fill <= w_fill_nxt;
    end
  end

  // Population count of the valid bits, used only by the invariant check.
  always_comb begin
    w_popcount = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_popcount = w_popcount + CNT_W'(r_vld[k]);
    end
  end

  assign q_o    = r_data[DEPTH-1];
  assign vld_o  = r_vld[DEPTH-1];
  assign fill_o = r_fill;
  assign full_o = (r_fill == CNT_W'(DEPTH));

`ifdef PIPE_DELAY_REG_TAPS_EN
  // Flatten the stage array onto the tap bus, stage k at [k*WIDTH +: WIDTH].
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps_o[g*WIDTH +: WIDTH] = r_data[g];
  end
  assign tap_vld_o = r_vld;
`else
  // Taps not built: stage contents are visible only through q_o / vld_o.
`endif

`ifndef SYNTHESIS
  // The counter must always agree with the number of valid stages.
  a_fill_matches_valid : assert property (
    @(posedge clk) disable iff (!reset) (r_fill == w_popcount)
  );

  // The counter can never exceed the number of stages.
  a_fill_bounded : assert property (
    @(posedge clk) disable iff (!reset) (r_fill <= CNT_W'(DEPTH))
  );
`endif

endmodule
